// File: rtl/j1_boot_pkg.sv
// Shared definitions for the j1 boot loader: FSM state encoding and frame constants.
package j1_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StCsum,
    StRun
  } boot_state_e;

  localparam logic [7:0]  MagicDefault = 8'hA5;
  localparam int unsigned HdrLen       = 3;

endpackage

// File: rtl/j1_boot_loader.sv
// Loads a framed byte stream into j1 program memory and holds the CPU in reset
// until a complete image with a matching checksum has been written.
module j1_boot_loader
  import j1_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter logic [7:0]  MAGIC  = MagicDefault
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload_i,
  output logic [ADDR_W-1:0] pgm_addr,
  output logic [15:0]       pgm_data,
  output logic              pgm_we,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  // Largest legal word count: the whole program memory.
  localparam logic [16:0] Cap = 17'd1 << ADDR_W;

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              acc;

  assign acc = rx_valid & rx_ready_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      csum_q     <= '0;
      len_hi_q   <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rx_ready_q <= rx_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    hi_d     = hi_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      StIdle: begin
        if (acc && rx_data == MAGIC) begin
          state_d = StLenHi;
          err_d   = 1'b0;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      StLenHi: begin
        if (acc) begin
          len_hi_d = rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (acc) begin
          len_d = {len_hi_q, rx_data};
          if (len_d == 16'd0) begin
            state_d = StCsum;
          end else if (17'(len_d) > Cap) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: begin
        if (acc) begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = StDatLo;
        end
      end
      StDatLo: begin
        if (acc) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          data_d  = {hi_q, rx_data};
          cnt_d   = cnt_q + 1'b1;
          csum_d  = csum_q + rx_data;
          state_d = (17'(cnt_d) == 17'(len_q)) ? StCsum : StDatHi;
        end
      end
      StCsum: begin
        if (acc) begin
          if (rx_data == csum_q) begin
            state_d = StRun;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StRun: begin
        if (reload_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs follow the state being entered so they change with it.
  always_comb begin
    rx_ready_d = (state_d != StRun);
    cpu_rst_d  = (state_d != StRun);
    done_d     = (state_d == StRun);
  end

  assign rx_ready  = rx_ready_q;
  assign pgm_we    = we_q;
  assign pgm_addr  = addr_q;
  assign pgm_data  = data_q;
  assign cpu_rst_o = cpu_rst_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Self-checking bench for j1_boot_loader: expected program writes are queued as
// bytes are sent and matched against the write port as it strobes.
module tb_j1_boot_loader;
  import j1_boot_pkg::*;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          reload = 1'b0;
  logic [AW-1:0] pgm_addr;
  logic [15:0]   pgm_data;
  logic          pgm_we;
  logic          cpu_rst, done, err;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned n_hs = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int unsigned   cyc;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] words[$];

  j1_boot_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (sys_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .reload_i  (reload),
    .pgm_addr  (pgm_addr),
    .pgm_data  (pgm_data),
    .pgm_we    (pgm_we),
    .cpu_rst_o (cpu_rst),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid && rx_ready) n_hs <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (pgm_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_we", {3'b0, pgm_addr, pgm_data}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr", {3'b0, pgm_addr, pgm_data}, {3'b0, e.addr, e.data});
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; returns just after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_ready) check("ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap, input bit bad);
    logic [7:0]  cs;
    logic [15:0] nn;
    logic [15:0] w;
    int unsigned hs0;
    cs  = '0;
    nn  = n[15:0];
    hs0 = n_hs;
    send_byte(8'hA5, gap);
    check("err_clear_at_magic", 32'(err), 32'd0);
    send_byte(nn[15:8], gap);
    send_byte(nn[7:0], gap);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
      sb.push_back('{addr: i[AW-1:0], data: w, cyc: cyc});
      cs = cs + w[15:8] + w[7:0];
    end
    send_byte(bad ? cs + 8'd1 : cs, gap);
    check("byte_count", n_hs - hs0, HdrLen + 2 * n + 1);
    if (bad) begin
      check("bad_err", 32'(err), 32'd1);
      check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
      check("bad_done", 32'(done), 32'd0);
    end else begin
      check("rel_cpu_rst", 32'(cpu_rst), 32'd0);
      check("rel_done", 32'(done), 32'd1);
      check("rel_rx_ready", 32'(rx_ready), 32'd0);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(pgm_we), 32'd0);
    check("rst_addr", 32'(pgm_addr), 32'd0);
    check("rst_data", 32'(pgm_data), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    sys_rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    send_frame(2, 1'b0, 1'b0);

    // reload_i in RUN; bad checksum, then a good frame clears the error
    do_reload();
    send_frame(2, 1'b0, 1'b1);
    check("reload_ignored_idle_rst", 32'(cpu_rst), 32'd1);
    send_frame(2, 1'b0, 1'b0);

    do_reload();
    send_frame(0, 1'b0, 1'b0);

    // oversize length is rejected right after LEN_LO
    do_reload();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h01, 1'b0);
    check("oversize_err", 32'(err), 32'd1);
    check("oversize_cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h13, 1'b0);
    check("garbage_err_kept", 32'(err), 32'd1);
    check("garbage_rx_ready", 32'(rx_ready), 32'd1);

    fill_words(4);
    send_frame(4, 1'b1, 1'b0);

    do_reload();
    fill_words(1);
    send_frame(1, 1'b0, 1'b0);

    // reset mid-frame: no write must appear at address 0
    do_reload();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_we", 32'(pgm_we), 32'd0);
    @(posedge clk);
    #1;
    fill_words(3);
    send_frame(3, 1'b0, 1'b0);

    // full-capacity image ends at the last address
    do_reload();
    fill_words(1 << AW);
    send_frame(1 << AW, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
